// File: rtl/rank_loader.sv
// rtl/rank_loader.sv - Collects (id, score) beats into a slot array, then sequences one sort-stage run.
module rank_loader #(
    parameter int DATA_WIDTH  = 16,
    parameter int NUM_WORDS   = 32,
    parameter int SORT_CYCLES = 275
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [5:0]                      in_id,
    input  logic [DATA_WIDTH-1:0]           in_data,
    input  logic                            in_last,
    input  logic                            start,
    output logic [DATA_WIDTH*NUM_WORDS-1:0] array_out,
    output logic                            sort_clr,
    output logic                            sort_en,
    output logic                            done,
    output logic                            dup_err,
    output logic                            range_err
);

    localparam int         IDX_W    = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam logic [8:0] LAST_CNT = 9'(SORT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_LOAD,
        ST_CLEAR,
        ST_SORT,
        ST_DONE
    } state_t;

    state_t                  r_state;
    state_t                  w_next;
    logic [NUM_WORDS-1:0]    r_written;
    logic [DATA_WIDTH-1:0]   r_mem [NUM_WORDS];
    logic [8:0]              r_cnt;
    logic                    r_dup_err;
    logic                    r_range_err;

    logic                    w_accept;
    logic                    w_in_range;
    logic [IDX_W-1:0]        w_idx;

    assign w_accept   = in_valid && (r_state == ST_LOAD);
    assign w_in_range = (32'(in_id) < NUM_WORDS);
    assign w_idx      = in_id[IDX_W-1:0];

    always_comb begin
        w_next   = r_state;
        in_ready = 1'b0;
        sort_clr = 1'b0;
        sort_en  = 1'b0;
        done     = 1'b0;
        case (r_state)
            ST_LOAD: begin
                in_ready = 1'b1;
                if (w_accept && in_last) w_next = ST_CLEAR;
            end
            ST_CLEAR: begin
                sort_clr = 1'b1;
                w_next   = ST_SORT;
            end
            ST_SORT: begin
                sort_en = 1'b1;
                if (r_cnt == LAST_CNT) w_next = ST_DONE;
            end
            ST_DONE: begin
                done = 1'b1;
                if (start) w_next = ST_LOAD;
            end
            default: w_next = ST_LOAD;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_LOAD;
            r_written   <= '0;
            r_cnt       <= '0;
            r_dup_err   <= 1'b0;
            r_range_err <= 1'b0;
        end else begin
            r_state <= w_next;
            case (r_state)
                ST_LOAD: begin
                    if (w_accept) begin
                        if (w_in_range) begin
                            r_written[w_idx] <= 1'b1;
                            if (r_written[w_idx]) r_dup_err <= 1'b1;
                        end else begin
                            r_range_err <= 1'b1;
                        end
                    end
                end
                ST_SORT: begin
                    if (r_cnt != LAST_CNT) r_cnt <= r_cnt + 9'd1;
                end
                ST_DONE: begin
                    if (start) begin
                        r_written   <= '0;
                        r_cnt       <= '0;
                        r_dup_err   <= 1'b0;
                        r_range_err <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Score storage is never reset; r_written masks stale contents on the output.
    always_ff @(posedge clk) begin
        if (w_accept && w_in_range) r_mem[w_idx] <= in_data;
    end

    for (genvar j = 0; j < NUM_WORDS; j++) begin : g_slot
        assign array_out[j*DATA_WIDTH +: DATA_WIDTH] = r_written[j] ? r_mem[j] : '0;
    end

    assign dup_err   = r_dup_err;
    assign range_err = r_range_err;

endmodule

// File: tb/tb_rank_loader.sv
// tb/tb_rank_loader.sv - Scoreboard bench for rank_loader: load, sort sequencing, errors, reset abort.
module tb_rank_loader;

    localparam int DW = 16;
    localparam int NW = 32;
    localparam int SC = 275;
    localparam int AW = DW * NW;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [5:0]    in_id;
    logic [DW-1:0] in_data;
    logic          in_last;
    logic          start;
    logic [AW-1:0] array_out;
    logic          sort_clr;
    logic          sort_en;
    logic          done;
    logic          dup_err;
    logic          range_err;

    rank_loader #(.DATA_WIDTH(DW), .NUM_WORDS(NW), .SORT_CYCLES(SC)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_id(in_id), .in_data(in_data), .in_last(in_last), .start(start),
        .array_out(array_out), .sort_clr(sort_clr), .sort_en(sort_en),
        .done(done), .dup_err(dup_err), .range_err(range_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [5:0]    slot;
        logic [DW-1:0] val;
    } exp_t;

    exp_t          exp_q[$];
    logic [1:0]    flag_q[$];
    logic [DW-1:0] mdl_mem [NW];
    logic [NW-1:0] mdl_wr;
    logic          mdl_dup;
    logic          mdl_rng;
    int            n_checks;
    int            n_pass;

    task automatic check(input string tag, input logic [AW-1:0] obs, input logic [AW-1:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic mdl_clear();
        mdl_wr  = '0;
        mdl_dup = 1'b0;
        mdl_rng = 1'b0;
    endtask

    task automatic send_beat(input logic [5:0] id, input logic [DW-1:0] d, input logic last);
        int waited;
        in_valid = 1'b1;
        in_id    = id;
        in_data  = d;
        in_last  = last;
        waited   = 0;
        while (!in_ready && waited < 10) begin
            @(posedge clk); #1;
            waited++;
        end
        if (waited >= 10) check("ready_timeout", AW'(in_ready), AW'(1));
        @(posedge clk);
        if (int'(id) < NW) begin
            if (mdl_wr[id]) mdl_dup = 1'b1;
            mdl_mem[id] = d;
            mdl_wr[id]  = 1'b1;
        end else begin
            mdl_rng = 1'b1;
        end
        if (last) begin
            for (int j = 0; j < NW; j++)
                exp_q.push_back('{slot: 6'(j), val: (mdl_wr[j] ? mdl_mem[j] : '0)});
            flag_q.push_back({mdl_dup, mdl_rng});
        end
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Called #1 after the edge that accepted the last beat; pokes ignored inputs mid-sort.
    task automatic run_sort();
        logic [AW-1:0] snap;
        int            n_en;
        int            n_clr;
        int            changed;
        bit            got_done;
        exp_t          e;
        logic [1:0]    f;
        check("clr_pulse", AW'(sort_clr), AW'(1));
        check("clr_not_ready", AW'(in_ready), AW'(0));
        check("clr_no_en", AW'(sort_en), AW'(0));
        snap = array_out;
        n_en = 0; n_clr = 0; changed = 0; got_done = 0;
        for (int c = 0; c < 400 && !got_done; c++) begin
            if (c == 5) begin
                in_valid = 1'b1; in_id = 6'd3; in_data = '1; in_last = 1'b1; start = 1'b1;
            end
            if (c == 6) start = 1'b0;
            @(posedge clk); #1;
            if (sort_en) n_en++;
            if (sort_clr) n_clr++;
            if (array_out !== snap) changed++;
            if (done) got_done = 1'b1;
        end
        in_valid = 1'b0; in_last = 1'b0; start = 1'b0;
        check("sort_en_cycles", AW'(n_en), AW'(SC));
        check("done_reached", AW'(got_done), AW'(1));
        check("extra_clr", AW'(n_clr), AW'(0));
        check("array_stable", AW'(changed), AW'(0));
        repeat (3) @(posedge clk);
        #1;
        check("done_held", AW'({done, sort_en, in_ready}), AW'(3'b100));
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check($sformatf("slot%0d", e.slot), AW'(array_out[int'(e.slot)*DW +: DW]), AW'(e.val));
        end
        if (flag_q.size() > 0) begin
            f = flag_q.pop_front();
            check("err_flags", AW'({dup_err, range_err}), AW'(f));
        end
    endtask

    task automatic do_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        mdl_clear();
        check("start_state", AW'({in_ready, done, sort_en}), AW'(3'b100));
        check("start_errs", AW'({dup_err, range_err}), AW'(2'b00));
        check("start_array", array_out, '0);
    endtask

    initial begin
        int n_en;
        rst = 1'b1; in_valid = 1'b0; in_id = '0; in_data = '0; in_last = 1'b0; start = 1'b0;
        n_checks = 0; n_pass = 0;
        mdl_clear();
        repeat (3) @(posedge clk);
        #1;
        check("rst_outs", AW'({sort_clr, sort_en, done, dup_err, range_err}), AW'(0));
        check("rst_array", array_out, '0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("rel_ready", AW'(in_ready), AW'(1));

        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("start_in_load", AW'({in_ready, sort_clr}), AW'(2'b10));

        // Full load, id j carries j*3
        for (int j = 0; j < NW; j++) send_beat(6'(j), DW'(j * 3), (j == NW - 1));
        run_sort();

        do_start();
        send_beat(6'd0, 16'd5, 1'b0);
        send_beat(6'd1, 16'd7, 1'b1);
        run_sort();

        do_start();
        send_beat(6'd4, 16'd10, 1'b0);
        check("dup_before", AW'(dup_err), AW'(0));
        send_beat(6'd4, 16'd20, 1'b0);
        check("dup_after", AW'(dup_err), AW'(1));
        send_beat(6'd40, 16'd9, 1'b1);
        check("range_set", AW'(range_err), AW'(1));
        run_sort();

        do_start();
        send_beat(6'd0, 16'd1, 1'b1);
        run_sort();

        // Abort mid-sort with an asynchronous reset at counter value 100
        do_start();
        send_beat(6'd9, 16'h1234, 1'b1);
        n_en = 0;
        for (int c = 0; c < 200 && n_en < 101; c++) begin
            @(posedge clk); #1;
            if (sort_en) n_en++;
        end
        check("abort_reached", AW'(n_en), AW'(101));
        #3;
        rst = 1'b1;
        #1;
        check("abort_drop", AW'({sort_en, done, sort_clr}), AW'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.delete();
        flag_q.delete();
        mdl_clear();
        @(posedge clk); #1;
        check("abort_load", AW'({in_ready, sort_en, sort_clr}), AW'(3'b100));
        check("abort_array", array_out, '0);

        send_beat(6'd31, 16'habcd, 1'b1);
        run_sort();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
